// File: rtl/qoa_slice_sequencer.sv
// QOA mono stream parser: header/LMS sequencing plus double-buffered slice residual issue; slice residuals appear 2 cycles after the slice's last byte.
// byte_valid cannot be stalled: a slice byte arriving while both slice buffers are full is dropped and ovf sticks.
module qoa_slice_sequencer #(
  parameter bit CHECK_MAGIC  = 1'b1,
  parameter int MAX_FSAMPLES = 5120
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        lms_wr,
  output logic        lms_sel,
  output logic [1:0]  lms_idx,
  output logic [15:0] lms_val,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_code,
  output logic [3:0]  res_sf,
  output logic        res_last,
  output logic        frame_done,
  output logic [23:0] samplerate,
  output logic [15:0] fsamples,
  output logic        err,
  output logic        ovf
);

  typedef enum logic [2:0] {FILE_HDR, FRAME_HDR, LMS_HIST, LMS_WGT, SLICE, ERR} state_t;

  state_t      state, state_nx;
  logic [2:0]  bcnt;
  logic [47:0] hdr_sr;
  logic [15:0] samples_left;

  logic [63:0] c_buf;
  logic        c_full;
  logic [4:0]  c_cnt;
  logic        c_last;

  logic [59:0] e_res;
  logic [3:0]  e_sf;
  logic        e_full;
  logic [4:0]  e_idx;
  logic [4:0]  e_cnt;
  logic        e_last;

  logic        hs, e_final, e_free, move;
  logic        slice_take, slice_done, last_slice, byte_ok, lms_fire, ovf_hit;
  logic [7:0]  magic_byte;
  logic        magic_bad;
  logic [15:0] hdr_fs;

  always_comb begin
    magic_byte = 8'h71;
    case (bcnt[1:0])
      2'd0: magic_byte = 8'h71;
      2'd1: magic_byte = 8'h6F;
      2'd2: magic_byte = 8'h61;
      2'd3: magic_byte = 8'h66;
      default: magic_byte = 8'h71;
    endcase
  end

  assign hs         = e_full && res_ready;
  assign e_final    = (e_idx == e_cnt - 5'd1);
  // E can take C this edge if empty or if its very last residual is leaving now
  assign e_free     = !e_full || (hs && e_final);
  assign move       = c_full && e_free;
  assign slice_take = byte_valid && (state == SLICE) && (!c_full || move);
  assign slice_done = slice_take && (bcnt == 3'd7);
  assign ovf_hit    = byte_valid && (state == SLICE) && c_full && !move;
  assign last_slice = (samples_left <= 16'd20);
  assign byte_ok    = byte_valid && (state != ERR) && ((state != SLICE) || slice_take);
  assign lms_fire   = byte_valid && ((state == LMS_HIST) || (state == LMS_WGT)) && bcnt[0];
  assign magic_bad  = CHECK_MAGIC && !bcnt[2] && (byte_in != magic_byte);
  assign hdr_fs     = hdr_sr[23:8];

  assign res_valid  = e_full;
  assign res_code   = e_res[59:57];
  assign res_sf     = e_sf;
  assign res_last   = e_full && e_last && e_final;

  always_comb begin
    state_nx = state;
    case (state)
      FILE_HDR: if (byte_valid) begin
        if (magic_bad)              state_nx = ERR;
        else if (bcnt == 3'd7)      state_nx = FRAME_HDR;
      end
      FRAME_HDR: if (byte_valid) begin
        if (bcnt == 3'd0 && byte_in != 8'd1) state_nx = ERR;
        else if (bcnt == 3'd7)
          state_nx = (hdr_fs > 16'(MAX_FSAMPLES)) ? ERR : LMS_HIST;
      end
      LMS_HIST: if (byte_valid && bcnt == 3'd7) state_nx = LMS_WGT;
      LMS_WGT:  if (byte_valid && bcnt == 3'd7)
        state_nx = (fsamples == 16'd0) ? FRAME_HDR : SLICE;
      SLICE:    if (slice_done && last_slice) state_nx = FRAME_HDR;
      ERR:      state_nx = ERR;
      default:  state_nx = ERR;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= FILE_HDR;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bcnt         <= '0;
      hdr_sr       <= '0;
      samples_left <= '0;
      c_buf        <= '0;
      c_full       <= 1'b0;
      c_cnt        <= '0;
      c_last       <= 1'b0;
      e_res        <= '0;
      e_sf         <= '0;
      e_full       <= 1'b0;
      e_idx        <= '0;
      e_cnt        <= '0;
      e_last       <= 1'b0;
      lms_wr       <= 1'b0;
      lms_sel      <= 1'b0;
      lms_idx      <= '0;
      lms_val      <= '0;
      frame_done   <= 1'b0;
      samplerate   <= '0;
      fsamples     <= '0;
      err          <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      lms_wr     <= lms_fire;
      frame_done <= (hs && res_last) ||
                    ((state == LMS_WGT) && byte_valid && (bcnt == 3'd7) && (fsamples == 16'd0));

      if (byte_ok) begin
        bcnt <= bcnt + 3'd1;
        if (state != SLICE) hdr_sr <= {hdr_sr[39:0], byte_in};
      end

      if (lms_fire) begin
        lms_sel <= (state == LMS_WGT);
        lms_idx <= bcnt[2:1];
        lms_val <= {hdr_sr[7:0], byte_in};
      end

      if ((state == FRAME_HDR) && byte_valid && (bcnt == 3'd7)) begin
        samplerate   <= hdr_sr[47:24];
        fsamples     <= hdr_fs;
        samples_left <= hdr_fs;
      end

      if (slice_take) c_buf <= {c_buf[55:0], byte_in};
      if (slice_done) begin
        c_cnt        <= last_slice ? samples_left[4:0] : 5'd20;
        c_last       <= last_slice;
        samples_left <= last_slice ? 16'd0 : samples_left - 16'd20;
      end
      c_full <= (c_full && !move) || slice_done;

      if (move) begin
        e_full <= 1'b1;
        e_res  <= c_buf[59:0];
        e_sf   <= c_buf[63:60];
        e_idx  <= '0;
        e_cnt  <= c_cnt;
        e_last <= c_last;
      end else if (hs) begin
        if (e_final) begin
          e_full <= 1'b0;
        end else begin
          e_idx <= e_idx + 5'd1;
          e_res <= {e_res[56:0], 3'b000};
        end
      end

      if (ovf_hit) ovf <= 1'b1;

      if (state_nx == ERR) begin
        err    <= 1'b1;
        c_full <= 1'b0;
        e_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qoa_slice_sequencer.sv
// Randomized stream bench for qoa_slice_sequencer against a queue-based frame/slice model.
module tb_qoa_slice_sequencer;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        lms_wr;
  logic        lms_sel;
  logic [1:0]  lms_idx;
  logic [15:0] lms_val;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_code;
  logic [3:0]  res_sf;
  logic        res_last;
  logic        frame_done;
  logic [23:0] samplerate;
  logic [15:0] fsamples;
  logic        err;
  logic        ovf;

  qoa_slice_sequencer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .lms_wr(lms_wr), .lms_sel(lms_sel), .lms_idx(lms_idx), .lms_val(lms_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_code(res_code), .res_sf(res_sf),
    .res_last(res_last), .frame_done(frame_done), .samplerate(samplerate),
    .fsamples(fsamples), .err(err), .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  stream[$];
  logic [18:0] exp_lms[$];
  logic [18:0] obs_lms[$];
  logic [7:0]  exp_res[$];
  logic [7:0]  obs_res[$];
  int          exp_fd, obs_fd, valid_cycles;
  int          ready_mode;
  logic [23:0] exp_sr;
  logic [15:0] exp_fs;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Response collector, sampled mid-cycle
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (lms_wr) obs_lms.push_back({lms_sel, lms_idx, lms_val});
        if (res_valid) valid_cycles++;
        if (res_valid && res_ready) obs_res.push_back({res_last, res_sf, res_code});
        if (frame_done) obs_fd++;
      end
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      case (ready_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic clear_model();
    stream.delete(); exp_lms.delete(); obs_lms.delete(); exp_res.delete(); obs_res.delete();
    exp_fd = 0; obs_fd = 0; valid_cycles = 0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    clear_model();
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_in = b; byte_valid = 1'b1;
    @(posedge sys_clk); #1;
    byte_valid = 1'b0;
    repeat (gap) begin @(posedge sys_clk); #1; end
  endtask

  task automatic send_stream();
    while (stream.size() > 0) send_byte(stream.pop_front(), int'($urandom_range(6, 9)));
  endtask

  task automatic add_file_hdr(input logic [7:0] m0);
    stream.push_back(m0); stream.push_back(8'h6F); stream.push_back(8'h61); stream.push_back(8'h66);
    for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
  endtask

  task automatic add_frame_hdr(input int ch, input logic [23:0] sr, input logic [15:0] fs);
    stream.push_back(8'(ch));
    stream.push_back(sr[23:16]); stream.push_back(sr[15:8]); stream.push_back(sr[7:0]);
    stream.push_back(fs[15:8]); stream.push_back(fs[7:0]);
    stream.push_back(8'($urandom)); stream.push_back(8'($urandom));
    exp_sr = sr; exp_fs = fs;
  endtask

  task automatic add_lms(input logic directed);
    logic [15:0] v;
    for (int i = 0; i < 8; i++) begin
      v = (directed && i == 0) ? 16'h1234 : 16'($urandom);
      stream.push_back(v[15:8]); stream.push_back(v[7:0]);
      exp_lms.push_back({(i >= 4), 2'(i % 4), v});
    end
  endtask

  task automatic add_frame(input int fs, input logic directed);
    logic [63:0] w;
    logic [2:0]  code;
    int n, cnt;
    add_frame_hdr(1, directed ? 24'd44100 : 24'($urandom_range(8000, 96000)), 16'(fs));
    add_lms(directed);
    exp_fd++;
    n = (fs + 19) / 20;
    for (int s = 0; s < n; s++) begin
      w = directed ? 64'hF000_0000_0000_0000 : {$urandom, $urandom};
      for (int b = 0; b < 8; b++) stream.push_back(w[63 - 8*b -: 8]);
      cnt = (s == n - 1) ? fs - 20 * (n - 1) : 20;
      for (int k = 0; k < cnt; k++) begin
        code = 3'(w >> (57 - 3*k));
        exp_res.push_back({(s == n - 1) && (k == cnt - 1), w[63:60], code});
      end
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (obs_res.size() < exp_res.size() && n < budget) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk({tag, "_drain_in_time"}, 64'(n < budget), 64'd1);
    repeat (4) begin @(posedge sys_clk); #1; end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_lms_count"}, 64'(obs_lms.size()), 64'(exp_lms.size()));
    for (int i = 0; i < exp_lms.size() && i < obs_lms.size(); i++)
      chk($sformatf("%s_lms%0d", tag, i), 64'(obs_lms[i]), 64'(exp_lms[i]));
    chk({tag, "_res_count"}, 64'(obs_res.size()), 64'(exp_res.size()));
    for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++)
      chk($sformatf("%s_res%0d", tag, i), 64'(obs_res[i]), 64'(exp_res[i]));
    chk({tag, "_frame_done"}, 64'(obs_fd), 64'(exp_fd));
    clear_model();
  endtask

  initial begin
    ready_mode = 1;
    byte_valid = 1'b0; byte_in = 8'h00;
    sys_rst_n  = 1'b0;
    clear_model();
    #12;
    chk("rst_res", 64'({res_valid, res_last, res_sf, res_code, frame_done}), 64'd0);
    chk("rst_lms", 64'({lms_wr, lms_sel, lms_idx, lms_val}), 64'd0);
    chk("rst_hdr", 64'({samplerate, fsamples}), 64'd0);
    chk("rst_flags", 64'({err, ovf}), 64'd0);
    do_reset();

    // Directed frame: fs=40, two 0xF000.. slices, always ready
    ready_mode = 1;
    add_file_hdr(8'h71);
    add_frame(40, 1'b1);
    send_stream();
    wait_drain("t1", 2000);
    chk("t1_samplerate", 64'(samplerate), 64'd44100);
    chk("t1_fsamples", 64'(fsamples), 64'd40);
    compare_all("t1");

    // Short last slice, random ready, continuing after the previous frame
    ready_mode = 2;
    add_frame(25, 1'b0);
    send_stream();
    wait_drain("t2", 2000);
    compare_all("t2");

    // Back-to-back random frames including empty and exact-multiple lengths
    add_frame(int'($urandom_range(1, 100)), 1'b0);
    add_frame(0, 1'b0);
    add_frame(int'($urandom_range(1, 60)), 1'b0);
    add_frame(20, 1'b0);
    send_stream();
    wait_drain("t3", 4000);
    chk("t3_samplerate", 64'(samplerate), 64'(exp_sr));
    chk("t3_fsamples", 64'(fsamples), 64'(exp_fs));
    chk("t3_flags", 64'({err, ovf}), 64'd0);
    compare_all("t3");

    // Overflow: decoder stalled while three slices arrive
    do_reset();
    ready_mode = 0;
    add_file_hdr(8'h71);
    add_frame(60, 1'b0);
    send_stream();
    chk("t4_ovf", 64'(ovf), 64'd1);
    chk("t4_valid", 64'(res_valid), 64'd1);
    while (exp_res.size() > 40) void'(exp_res.pop_back());
    exp_fd = 0;
    ready_mode = 1;
    wait_drain("t4", 2000);
    compare_all("t4");

    // Reset while residuals are pending
    do_reset();
    ready_mode = 0;
    add_file_hdr(8'h71);
    add_frame(40, 1'b0);
    send_stream();
    chk("t5_pending", 64'(res_valid), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_async_clear", 64'({res_valid, lms_wr, frame_done}), 64'd0);
    do_reset();
    ready_mode = 2;
    add_file_hdr(8'h71);
    add_frame(30, 1'b0);
    send_stream();
    wait_drain("t5", 2000);
    compare_all("t5");

    // Bad magic locks the parser until reset
    do_reset();
    ready_mode = 1;
    add_file_hdr(8'h70);
    add_frame(40, 1'b0);
    send_stream();
    repeat (20) begin @(posedge sys_clk); #1; end
    chk("t6_err", 64'(err), 64'd1);
    chk("t6_no_lms", 64'(obs_lms.size()), 64'd0);
    chk("t6_no_valid", 64'(valid_cycles), 64'd0);
    do_reset();
    chk("t6_err_cleared", 64'(err), 64'd0);

    // Stereo header rejected
    add_file_hdr(8'h71);
    add_frame_hdr(2, 24'd48000, 16'd40);
    add_lms(1'b0);
    send_stream();
    repeat (20) begin @(posedge sys_clk); #1; end
    chk("t7_err", 64'(err), 64'd1);
    chk("t7_no_lms", 64'(obs_lms.size()), 64'd0);
    chk("t7_no_valid", 64'(valid_cycles), 64'd0);

    // Frame length one above the limit
    do_reset();
    add_file_hdr(8'h71);
    add_frame_hdr(1, 24'd22050, 16'd5121);
    add_lms(1'b0);
    send_stream();
    repeat (20) begin @(posedge sys_clk); #1; end
    chk("t8_err", 64'(err), 64'd1);
    chk("t8_no_lms", 64'(obs_lms.size()), 64'd0);

    // Frame length exactly at the limit is accepted
    do_reset();
    add_file_hdr(8'h71);
    add_frame_hdr(1, 24'd22050, 16'd5120);
    add_lms(1'b0);
    send_stream();
    repeat (20) begin @(posedge sys_clk); #1; end
    chk("t9_err", 64'(err), 64'd0);
    chk("t9_fsamples", 64'(fsamples), 64'd5120);
    compare_all("t9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
